vga_rect_master: RTL

VGA_RECT_MASTER -- requirements
Module: vga_rect_master

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_xy_counter.sv | 46 ++++
 rtl/vga_rect_master.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen defaults, FSM states, rectangle bounds and pixel word packing
package vga_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam int COL_LSB = 16;
  localparam int X_LSB   = 8;
  localparam int Y_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
  } rect_t;

  localparam int RECT_W = $bits(rect_t);

  function automatic logic [31:0] pack_pixel(input logic [2:0] c, input logic [7:0] x,
                                             input logic [6:0] y);
    logic [31:0] w;
    w = '0;
    w[COL_LSB +: 3] = c;
    w[X_LSB +: 8]   = x;
    w[Y_LSB +: 7]   = y;
    return w;
  endfunction

endpackage

// File: rtl/vga_xy_counter.sv
// rtl/vga_xy_counter.sv - raster walker over a latched rectangle, x inner and y outer
module vga_xy_counter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [RECT_W-1:0] bounds,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic              last
);

  rect_t      r_bounds;
  logic [7:0] r_x;
  logic [6:0] r_y;
  rect_t      w_in;

  assign w_in = rect_t'(bounds);

  // x only increments while below x1, so 8 bits cannot wrap even at column 255
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bounds <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (load) begin
      r_bounds <= w_in;
      r_x      <= w_in.x0;
      r_y      <= w_in.y0;
    end else if (advance) begin
      if (r_x == r_bounds.x1) begin
        r_x <= r_bounds.x0;
        r_y <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = (r_x == r_bounds.x1) && (r_y == r_bounds.y1);

endmodule

// File: rtl/vga_rect_master.sv
// rtl/vga_rect_master.sv - fills a clamped rectangle with one colour via Avalon-MM pixel writes
module vga_rect_master
  import vga_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [6:0]  y0,
  input  logic [6:0]  y1,
  input  logic [2:0]  colour,
  output logic        busy,
  output logic        done,
  output logic [3:0]  master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
);

  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [8:0] X_MAX   = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);
  localparam logic [7:0] Y_MAX   = 8'(SCREEN_H - 1);

  state_t     r_state;
  logic [2:0] r_colour;
  logic       r_busy;
  logic       r_done;
  logic       r_write;

  logic [7:0] w_x1_clamped;
  logic [6:0] w_y1_clamped;
  logic       w_reject;
  rect_t      w_bounds;
  logic       w_accept;
  logic       w_xfer;
  logic       w_advance;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic       w_last;

  always_comb begin
    w_x1_clamped = ({1'b0, x1} > X_MAX) ? X_MAX[7:0] : x1;
    w_y1_clamped = ({1'b0, y1} > Y_MAX) ? Y_MAX[6:0] : y1;
    w_reject     = (x0 > w_x1_clamped) || (y0 > w_y1_clamped) ||
                   ({1'b0, x0} >= X_LIMIT) || ({1'b0, y0} >= Y_LIMIT);
    w_bounds     = '{x0: x0, x1: w_x1_clamped, y0: y0, y1: w_y1_clamped};
  end

  assign w_accept  = (r_state == IDLE) && start;
  assign w_xfer    = (r_state == WRITE) && r_write && !master_waitrequest;
  assign w_advance = w_xfer && !w_last;

  vga_xy_counter u_xy (
    .clk     (clk),
    .reset   (reset),
    .load    (w_accept),
    .advance (w_advance),
    .bounds  (w_bounds),
    .x       (w_x),
    .y       (w_y),
    .last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_colour <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_write  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_colour <= colour;
            if (w_reject) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WRITE;
              r_busy  <= 1'b1;
              r_write <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_xfer && w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_write <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  // pixel word comes straight from the counter flops, so it holds still through a stall
  assign master_writedata = pack_pixel(r_colour, w_x, w_y);
  assign master_address   = 4'b0000;
  assign master_write     = r_write;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule
